// File: rtl/sparse_mult_ctrl.sv
// sparse_mult_ctrl
// Sequencer for a shift-and-XOR cyclic sparse x dense multiplier (mod x^n-1,
// n = N_WORDS*WORD_WIDTH). Positions arrive in (high, low) pairs. For each
// pair the block walks the accumulator word by word. For each word it
// issues the two dense-window word addresses per position and the bit
// offsets. One cycle later it writes the datapath result back. Dummy pairs
// follow the same schedule but write to a scratch bank. The real/dummy mix
// therefore does not show in timing or addressing.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start / busy / done             job control (done is a 1-cycle pulse)
//   pos_valid / pos_ready           pair stream handshake
//   pos_high, pos_low               sparse positions of the pair
//   pos_dummy, pos_last             pair is dummy / final pair of job
//   dense_raddr_{hl,hr,ll,lr}       window word addresses (issue cycle)
//   acc_raddr                       accumulator read address (issue cycle)
//   high_start, low_start           bit offsets, aligned with read data
//   xor_result                      combinational datapath result
//   acc_we / acc_dummy_we           real / scratch bank write enables
//   acc_waddr, acc_wdata            shared write address and data
module sparse_mult_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int N_WORDS    = 8,
    parameter int ADDR_W     = 3,
    parameter int POS_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  pos_valid,
    output logic                  pos_ready,
    input  logic [POS_W-1:0]      pos_high,
    input  logic [POS_W-1:0]      pos_low,
    input  logic                  pos_dummy,
    input  logic                  pos_last,
    output logic [ADDR_W-1:0]     dense_raddr_hl,
    output logic [ADDR_W-1:0]     dense_raddr_hr,
    output logic [ADDR_W-1:0]     dense_raddr_ll,
    output logic [ADDR_W-1:0]     dense_raddr_lr,
    output logic [ADDR_W-1:0]     acc_raddr,
    output logic [5:0]            high_start,
    output logic [5:0]            low_start,
    input  logic [WORD_WIDTH-1:0] xor_result,
    output logic                  acc_we,
    output logic                  acc_dummy_we,
    output logic [ADDR_W-1:0]     acc_waddr,
    output logic [WORD_WIDTH-1:0] acc_wdata
);

    localparam int LOG_W = $clog2(WORD_WIDTH);
    localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    // j counts clear words in CLEAR and issued words in RUN; it wraps to 0
    // at the end of CLEAR and at the end of every pair.
    logic [ADDR_W-1:0]   j_q, j_d;
    logic                held_q, held_d;
    logic [POS_W-1:0]    high_q, high_d;
    logic [POS_W-1:0]    low_q, low_d;
    logic                dummy_q, dummy_d;
    logic                last_q, last_d;

    // Stage 1: issue-cycle context re-timed to meet the memory read data.
    logic                s1_vld_q, s1_vld_d;
    logic                s1_dummy_q, s1_dummy_d;
    logic [ADDR_W-1:0]   s1_j_q, s1_j_d;
    logic [5:0]          s1_hs_q, s1_hs_d;
    logic [5:0]          s1_ls_q, s1_ls_d;

    logic                issue;
    logic                last_word;
    logic                load;
    logic [ADDR_W-1:0]   q_h, q_l;
    logic [5:0]          hs, ls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            held_q     <= 1'b0;
            high_q     <= '0;
            low_q      <= '0;
            dummy_q    <= 1'b0;
            last_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_dummy_q <= 1'b0;
            s1_j_q     <= '0;
            s1_hs_q    <= '0;
            s1_ls_q    <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            held_q     <= held_d;
            high_q     <= high_d;
            low_q      <= low_d;
            dummy_q    <= dummy_d;
            last_q     <= last_d;
            s1_vld_q   <= s1_vld_d;
            s1_dummy_q <= s1_dummy_d;
            s1_j_q     <= s1_j_d;
            s1_hs_q    <= s1_hs_d;
            s1_ls_q    <= s1_ls_d;
        end
    end

    // Position decomposition: word offset q and bit offset b (start = W-b).
    assign q_h = high_q[LOG_W +: ADDR_W];
    assign q_l = low_q[LOG_W +: ADDR_W];
    assign hs  = 6'(WORD_WIDTH) - 6'(high_q[LOG_W-1:0]);
    assign ls  = 6'(WORD_WIDTH) - 6'(low_q[LOG_W-1:0]);

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        held_d     = held_q;
        high_d     = high_q;
        low_d      = low_q;
        dummy_d    = dummy_q;
        last_d     = last_q;
        s1_vld_d   = 1'b0;
        s1_dummy_d = 1'b0;
        s1_j_d     = '0;
        s1_hs_d    = '0;
        s1_ls_d    = '0;

        issue     = (state_q == S_RUN) && held_q;
        last_word = (j_q == LAST_J);
        // A new pair may land on the cycle the held pair issues its last
        // word, giving back-to-back pairs with no bubble. Once the final
        // pair of the job is held, nothing more is accepted.
        pos_ready = (state_q == S_RUN) && (!held_q || (last_word && !last_q));
        load      = pos_valid && pos_ready;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    j_d     = '0;
                end
            end
            S_CLEAR: begin
                j_d    = j_q + 1'b1;
                held_d = 1'b0;
                last_d = 1'b0;
                if (last_word) state_d = S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    j_d        = j_q + 1'b1;
                    s1_vld_d   = 1'b1;
                    s1_dummy_d = dummy_q;
                    s1_j_d     = j_q;
                    s1_hs_d    = hs;
                    s1_ls_d    = ls;
                    if (last_word) begin
                        held_d = 1'b0;
                        if (last_q) state_d = S_DRAIN;
                    end
                end
                if (load) begin
                    held_d  = 1'b1;
                    high_d  = pos_high;
                    low_d   = pos_low;
                    dummy_d = pos_dummy;
                    last_d  = pos_last;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);

        // Addresses are held at 0 outside issue cycles so idle outputs are
        // quiet (the raw right-window formula would read N_WORDS-1).
        dense_raddr_hl = '0;
        dense_raddr_hr = '0;
        dense_raddr_ll = '0;
        dense_raddr_lr = '0;
        acc_raddr      = '0;
        if (issue) begin
            dense_raddr_hl = j_q - q_h;
            dense_raddr_hr = j_q - q_h - 1'b1;
            dense_raddr_ll = j_q - q_l;
            dense_raddr_lr = j_q - q_l - 1'b1;
            acc_raddr      = j_q;
        end

        high_start   = s1_hs_q;
        low_start    = s1_ls_q;
        acc_dummy_we = s1_vld_q && s1_dummy_q;
        acc_we       = (state_q == S_CLEAR) || (s1_vld_q && !s1_dummy_q);
        acc_waddr    = '0;
        acc_wdata    = '0;
        if (state_q == S_CLEAR) begin
            acc_waddr = j_q;
        end else if (s1_vld_q) begin
            acc_waddr = s1_j_q;
            acc_wdata = xor_result;
        end
    end

endmodule

// File: tb/tb_sparse_mult_ctrl.sv
module tb_sparse_mult_ctrl;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic          pos_valid = 1'b0;
    logic          pos_ready;
    logic [PW-1:0] pos_high = '0;
    logic [PW-1:0] pos_low = '0;
    logic          pos_dummy = 1'b0;
    logic          pos_last = 1'b0;
    logic [AW-1:0] hl, hr, ll, lr, acc_raddr, acc_waddr;
    logic [5:0]    high_start, low_start;
    logic [W-1:0]  xor_result, acc_wdata;
    logic          acc_we, acc_dummy_we;

    sparse_mult_ctrl #(.WORD_WIDTH(W), .N_WORDS(N), .ADDR_W(AW), .POS_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_high(pos_high),
        .pos_low(pos_low), .pos_dummy(pos_dummy), .pos_last(pos_last),
        .dense_raddr_hl(hl), .dense_raddr_hr(hr), .dense_raddr_ll(ll),
        .dense_raddr_lr(lr), .acc_raddr(acc_raddr), .high_start(high_start),
        .low_start(low_start), .xor_result(xor_result), .acc_we(acc_we),
        .acc_dummy_we(acc_dummy_we), .acc_waddr(acc_waddr), .acc_wdata(acc_wdata)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: one-cycle registered read addresses packed with the
    // offsets, so each written word exposes its full issue context.
    logic [14:0] rd_q;
    always @(posedge clk) rd_q <= {hl, hr, ll, lr, acc_raddr};
    assign xor_result = {5'b0, rd_q, high_start, low_start};

    typedef struct {
        logic         we;
        logic         dwe;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  start_cyc = 0;
    bit  time_chk = 0;
    int  dummy_cnt = 0;
    int  data_cnt = 0;
    int  first_t = 0;
    int  last_t = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected write data for word j of pair (h, l), from the window rules.
    function automatic logic [W-1:0] model(input logic [PW-1:0] h, input logic [PW-1:0] l, input int j);
        int qh, bh, ql, bl;
        logic [2:0] ehl, ehr, ell, elr, ej;
        logic [5:0] ehs, els;
        qh  = int'(h) / 32;  bh = int'(h) % 32;
        ql  = int'(l) / 32;  bl = int'(l) % 32;
        ehl = 3'((j - qh + 2 * N) % N);
        ehr = 3'((j - qh - 1 + 2 * N) % N);
        ell = 3'((j - ql + 2 * N) % N);
        elr = 3'((j - ql - 1 + 2 * N) % N);
        ej  = 3'(j);
        ehs = 6'(32 - bh);
        els = 6'(32 - bl);
        return {5'b0, ehl, ehr, ell, elr, ej, ehs, els};
    endfunction

    // Monitor: pops the scoreboard on every write the DUT presents.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                if (time_chk) begin
                    check("done_latency", 64'(cyc - start_cyc), 64'd19);
                    time_chk = 0;
                end
            end
            if (acc_we || acc_dummy_we) begin
                check("we_exclusive", 64'(acc_we & acc_dummy_we), 64'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected", acc_waddr, acc_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("acc_we", 64'(acc_we), 64'(e.we));
                    check("acc_dummy_we", 64'(acc_dummy_we), 64'(e.dwe));
                    check("acc_waddr", 64'(acc_waddr), 64'(e.addr));
                    check("acc_wdata", 64'(acc_wdata), 64'(e.data));
                end
                if (acc_dummy_we) dummy_cnt++;
                if (acc_wdata != '0) begin
                    if (data_cnt == 0) first_t = cyc;
                    last_t = cyc;
                    data_cnt++;
                end
            end
        end
    end

    task automatic do_start(input bit tchk);
        wr_t e;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        time_chk = tchk;
        for (int k = 0; k < N; k++) begin
            e.we = 1'b1; e.dwe = 1'b0; e.addr = AW'(k); e.data = '0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [PW-1:0] h, input logic [PW-1:0] l, input bit d, input bit last);
        int n;
        wr_t e;
        pos_high = h; pos_low = l; pos_dummy = d; pos_last = last;
        pos_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pos_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (!pos_ready) begin
            n_fail++;
            $display("FAIL pair_accept: pos_ready %0b after %0d cycles, expected 1", pos_ready, n);
            pos_valid = 1'b0;
            return;
        end
        for (int j = 0; j < N; j++) begin
            e.we = !d; e.dwe = d; e.addr = AW'(j); e.data = model(h, l, j);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        pos_valid = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: done %0b after %0d cycles, expected 1", done, n);
            return;
        end
        if (poke) begin
            start = 1'b1;   // lands in the DONE cycle; must be ignored
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check(name, 64'({busy, done, pos_ready, hl, hr, ll, lr, acc_raddr, high_start,
                         low_start, acc_we, acc_dummy_we, acc_waddr, acc_wdata}), 64'd0);
    endtask

    initial begin
        int d0;
        #2;
        check_quiet("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("idle_busy", 64'(busy), 64'd0);

        // Single pair 0/33
        do_start(1);
        send_pair(8'd0, 8'd33, 1'b0, 1'b1);
        wait_done(0);

        // Single pair 5/255
        do_start(1);
        send_pair(8'd5, 8'd255, 1'b0, 1'b1);
        wait_done(0);

        // Three back-to-back pairs, middle dummy
        dummy_cnt = 0; data_cnt = 0;
        do_start(0);
        send_pair(8'd10, 8'd100, 1'b0, 1'b0);
        send_pair(8'd200, 8'd7, 1'b1, 1'b0);
        send_pair(8'd64, 8'd128, 1'b0, 1'b1);
        wait_done(0);
        check("dummy_we_count", 64'(dummy_cnt), 64'd8);
        check("issue_count_3pair", 64'(data_cnt), 64'd24);
        check("issue_span_3pair", 64'(last_t - first_t + 1), 64'd24);

        // Pair gap of 3 cycles, start poked during RUN and during DONE
        dummy_cnt = 0; data_cnt = 0;
        do_start(0);
        send_pair(8'd1, 8'd2, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send_pair(8'd70, 8'd180, 1'b0, 1'b1);
        wait_done(1);
        check("issue_count_gap", 64'(data_cnt), 64'd16);
        check("issue_span_gap", 64'(last_t - first_t + 1), 64'd19);
        check("start_in_done_ignored", 64'(busy), 64'd0);

        // Reset in the middle of RUN
        do_start(0);
        send_pair(8'd3, 8'd4, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        time_chk = 0;
        #1;
        check_quiet("midrun_reset_outputs");
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("midrun_reset_idle", 64'(busy), 64'd0);
        check("midrun_reset_no_done", 64'(done_cnt), 64'(d0));

        // Clean job after the abort
        do_start(1);
        send_pair(8'd0, 8'd33, 1'b0, 1'b1);
        wait_done(0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("done_pulse_count", 64'(done_cnt), 64'd5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
